// File: rtl/modexp_operand_buffer_pkg.sv
// rtl/modexp_operand_buffer_pkg.sv - shared defaults and state encoding for the ModExp operand buffer
package modexp_operand_buffer_pkg;

   localparam int DATA_WIDTH_DEF   = 128;
   localparam int NUM_WORDS_DEF    = 32;
   localparam int NUM_OPERANDS_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_DONE    = 3'd3,
      ST_UNLOAD  = 3'd4
   } buf_state_t;

   // Slot index width; a single slot still needs a one-bit select.
   function automatic int op_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/modexp_word_ram.sv
// rtl/modexp_word_ram.sv - word array with one synchronous write port and one asynchronous read port
module modexp_word_ram #(
   parameter int WIDTH = 128,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];

   // Storage carries no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/modexp_operand_buffer.sv
// rtl/modexp_operand_buffer.sv - operand collection, compute gating and result unload for the ModExp core
module modexp_operand_buffer
   import modexp_operand_buffer_pkg::*;
#(
   parameter  int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter  int NUM_WORDS    = NUM_WORDS_DEF,
   parameter  int NUM_OPERANDS = NUM_OPERANDS_DEF,
   localparam int OP_W         = op_width(NUM_OPERANDS),
   localparam int IDX_W        = $clog2(NUM_WORDS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    startInput,
   input  logic [OP_W-1:0]         opSel,
   input  logic                    inValid,
   input  logic [DATA_WIDTH-1:0]   inp,
   input  logic                    startCompute,
   input  logic                    getResult,
   output logic [NUM_OPERANDS-1:0] opLoaded,
   output logic                    computeGo,
   input  logic [OP_W-1:0]         rdOp,
   input  logic [IDX_W-1:0]        rdAddr,
   output logic [DATA_WIDTH-1:0]   rdData,
   input  logic                    resWe,
   input  logic [IDX_W-1:0]        resAddr,
   input  logic [DATA_WIDTH-1:0]   resData,
   input  logic                    resDone,
   output logic                    outValid,
   output logic [DATA_WIDTH-1:0]   outp,
   output logic                    outLast,
   output logic [2:0]              state,
   output logic                    err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   buf_state_t              state_q, state_d;
   logic [OP_W-1:0]         op_q, op_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_OPERANDS-1:0] loaded_q, loaded_d;
   logic                    go_q, go_d;
   logic                    err_q, err_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic [DATA_WIDTH-1:0]   outp_q, outp_d;
   logic                    op_we;
   logic                    res_we;
   logic [IDX_W-1:0]        res_raddr;
   logic [DATA_WIDTH-1:0]   res_rdata;

   // Slots are packed as {slot, word} so the array is addressed without a multiplier.
   modexp_word_ram #(
      .WIDTH (DATA_WIDTH),
      .AW    (OP_W + IDX_W)
   ) u_operand_ram (
      .clk   (clk),
      .we    (op_we),
      .waddr ({op_q, idx_q}),
      .wdata (inp),
      .raddr ({rdOp, rdAddr}),
      .rdata (rdData)
   );

   // Result words are only accepted while the core is computing.
   assign res_we = (state_q == ST_COMPUTE) && resWe;

   // Read ahead by one so the registered outp already holds the word to present next.
   assign res_raddr = (state_q == ST_UNLOAD) ? idx_q + 1'b1 : '0;

   modexp_word_ram #(
      .WIDTH (DATA_WIDTH),
      .AW    (IDX_W)
   ) u_result_ram (
      .clk   (clk),
      .we    (res_we),
      .waddr (resAddr),
      .wdata (resData),
      .raddr (res_raddr),
      .rdata (res_rdata)
   );

   // State and output registers; reset aborts any transfer immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         idx_q    <= '0;
         loaded_q <= '0;
         go_q     <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         outp_q   <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         loaded_q <= loaded_d;
         go_q     <= go_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         outp_q   <= outp_d;
      end
   end

   // Next-state, handshake and protocol-violation logic.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      idx_d    = idx_q;
      loaded_d = loaded_q;
      go_d     = 1'b0;
      err_d    = err_q;
      valid_d  = valid_q;
      last_d   = last_q;
      outp_d   = outp_q;
      op_we    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (startInput) begin
               if (startCompute) begin
                  err_d = 1'b1;
               end
               if (int'(opSel) < NUM_OPERANDS) begin
                  op_d            = opSel;
                  idx_d           = '0;
                  loaded_d[opSel] = 1'b0;
                  state_d         = ST_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end else if (startCompute) begin
               if (&loaded_q) begin
                  state_d = ST_COMPUTE;
                  go_d    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            if (startInput || startCompute) begin
               err_d = 1'b1;
            end
            if (inValid) begin
               op_we = 1'b1;
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  loaded_d[op_q] = 1'b1;
                  idx_d          = '0;
                  state_d        = ST_IDLE;
               end
            end
         end

         ST_COMPUTE: begin
            if (startInput || startCompute) begin
               err_d = 1'b1;
            end
            if (resDone) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (startInput || startCompute) begin
               err_d = 1'b1;
            end
            if (getResult) begin
               state_d = ST_UNLOAD;
               idx_d   = '0;
               valid_d = 1'b1;
               last_d  = (NUM_WORDS == 1);
               outp_d  = res_rdata;
            end
         end

         ST_UNLOAD: begin
            if (startInput || startCompute) begin
               err_d = 1'b1;
            end
            if (getResult) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  outp_d  = '0;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  last_d = (idx_d == LAST_IDX);
                  outp_d = res_rdata;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            outp_d  = '0;
         end
      endcase
   end

   assign state     = state_q;
   assign opLoaded  = loaded_q;
   assign computeGo = go_q;
   assign err       = err_q;
   assign outValid  = valid_q;
   assign outLast   = last_q;
   assign outp      = outp_q;

endmodule

// File: tb/tb_modexp_operand_buffer.sv
// tb/tb_modexp_operand_buffer.sv - directed self-checking bench for modexp_operand_buffer
module tb_modexp_operand_buffer;

   logic         clk;
   logic         reset;
   logic         startInput;
   logic [1:0]   opSel;
   logic         inValid;
   logic [127:0] inp;
   logic         startCompute;
   logic         getResult;
   logic [3:0]   opLoaded;
   logic         computeGo;
   logic [1:0]   rdOp;
   logic [4:0]   rdAddr;
   logic [127:0] rdData;
   logic         resWe;
   logic [4:0]   resAddr;
   logic [127:0] resData;
   logic         resDone;
   logic         outValid;
   logic [127:0] outp;
   logic         outLast;
   logic [2:0]   state;
   logic         err;

   int n_vec  = 0;
   int n_miss = 0;

   modexp_operand_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .startInput   (startInput),
      .opSel        (opSel),
      .inValid      (inValid),
      .inp          (inp),
      .startCompute (startCompute),
      .getResult    (getResult),
      .opLoaded     (opLoaded),
      .computeGo    (computeGo),
      .rdOp         (rdOp),
      .rdAddr       (rdAddr),
      .rdData       (rdData),
      .resWe        (resWe),
      .resAddr      (resAddr),
      .resData      (resData),
      .resDone      (resDone),
      .outValid     (outValid),
      .outp         (outp),
      .outLast      (outLast),
      .state        (state),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input string tag, input int op, input int addr, input logic [127:0] exp);
      rdOp   = op[1:0];
      rdAddr = addr[4:0];
      #1;
      check_value(tag, rdData, exp);
   endtask

   task automatic reset_checks(input string pfx);
      check_value({pfx, "_state"},     128'(state),     128'd0);
      check_value({pfx, "_opLoaded"},  128'(opLoaded),  128'd0);
      check_value({pfx, "_computeGo"}, 128'(computeGo), 128'd0);
      check_value({pfx, "_outValid"},  128'(outValid),  128'd0);
      check_value({pfx, "_outLast"},   128'(outLast),   128'd0);
      check_value({pfx, "_outp"},      outp,            128'd0);
      check_value({pfx, "_err"},       128'(err),       128'd0);
   endtask

   // Word w of a load carries base + w + 1; gap inserts an idle cycle before every word.
   task automatic load_slot(input int op, input logic [127:0] base, input bit gap);
      opSel      = op[1:0];
      startInput = 1'b1;
      tick();
      startInput = 1'b0;
      check_value("load_started", 128'(state), 128'd1);
      check_value("load_clear", 128'(opLoaded[op]), 128'd0);
      for (int w = 0; w < 32; w++) begin
         if (gap) begin
            inValid = 1'b0;
            tick();
         end
         if (w == 31) check_value("load_busy", 128'(state), 128'd1);
         inValid = 1'b1;
         inp     = base + 128'(w + 1);
         tick();
      end
      inValid = 1'b0;
      check_value("load_idle", 128'(state), 128'd0);
      check_value("load_set", 128'(opLoaded[op]), 128'd1);
   endtask

   initial begin
      int go_cnt;
      int widx;
      int k;

      reset = 1'b0; startInput = 1'b0; opSel = '0; inValid = 1'b0; inp = '0;
      startCompute = 1'b0; getResult = 1'b0; rdOp = '0; rdAddr = '0;
      resWe = 1'b0; resAddr = '0; resData = '0; resDone = 1'b0;
      tick();
      tick();
      reset_checks("rst");
      reset = 1'b1;
      tick();

      // Four back-to-back loads, each started the cycle after the previous one finished.
      for (int s = 0; s < 4; s++) load_slot(s, 128'(s) << 8, 1'b0);
      check_value("all_loaded", 128'(opLoaded), 128'hf);
      check_value("load_err", 128'(err), 128'd0);
      rd_check("rd_op2_a5", 2, 5, 128'h206);
      rd_check("rd_op0_a0", 0, 0, 128'h001);
      rd_check("rd_op3_a31", 3, 31, 128'h320);

      // Reload slot 1 with inValid toggling; other slots must be untouched.
      load_slot(1, 128'hA00, 1'b1);
      check_value("reload_loaded", 128'(opLoaded), 128'hf);
      check_value("reload_err", 128'(err), 128'd0);
      rd_check("rd_op1_a0", 1, 0, 128'hA01);
      rd_check("rd_op1_a17", 1, 17, 128'hA12);
      rd_check("rd_op1_a31", 1, 31, 128'hA20);
      rd_check("rd_op2_keep", 2, 5, 128'h206);

      // Compute: a single computeGo pulse, core writes result[i] = 0x100 + i.
      go_cnt = 0;
      startCompute = 1'b1;
      tick();
      startCompute = 1'b0;
      check_value("compute_state", 128'(state), 128'd2);
      check_value("compute_go", 128'(computeGo), 128'd1);
      go_cnt += int'(computeGo);
      for (int i = 0; i < 32; i++) begin
         resWe   = 1'b1;
         resAddr = i[4:0];
         resData = 128'h100 + 128'(i);
         tick();
         go_cnt += int'(computeGo);
      end
      resWe   = 1'b0;
      resDone = 1'b1;
      tick();
      resDone = 1'b0;
      go_cnt += int'(computeGo);
      check_value("go_pulses", 128'(go_cnt), 128'd1);
      check_value("done_state", 128'(state), 128'd3);
      resWe   = 1'b1;
      resAddr = 5'd3;
      resData = 128'hBAD;
      tick();
      resWe = 1'b0;
      check_value("done_outValid", 128'(outValid), 128'd0);

      // Unload with getResult high 10, low 5, then high until the last word is taken.
      widx = 0;
      k    = 0;
      while (widx < 32 && k < 60) begin
         getResult = (k < 10 || k >= 15);
         if (k >= 10 && k < 15) check_value("hold_valid", 128'(outValid), 128'd1);
         if (outValid && getResult) begin
            check_value("unload_word", outp, 128'h100 + 128'(widx));
            check_value("unload_last", 128'(outLast), 128'(widx == 31));
            widx++;
         end
         tick();
         k++;
      end
      getResult = 1'b0;
      check_value("unload_count", 128'(widx), 128'd32);
      check_value("unload_state", 128'(state), 128'd0);
      check_value("unload_valid", 128'(outValid), 128'd0);
      check_value("unload_err", 128'(err), 128'd0);

      // Reset in the middle of a load, while word 17 is presented.
      opSel      = 2'd0;
      startInput = 1'b1;
      tick();
      startInput = 1'b0;
      for (int w = 0; w < 17; w++) begin
         inValid = 1'b1;
         inp     = 128'(w + 1);
         tick();
      end
      check_value("midload_state", 128'(state), 128'd1);
      inp   = 128'd18;
      reset = 1'b0;
      #1;
      reset_checks("midrst");
      inValid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Reload three slots, then a compute request without slot 3 must be refused.
      for (int s = 0; s < 3; s++) load_slot(s, 128'h5000 + (128'(s) << 8), 1'b0);
      check_value("partial_loaded", 128'(opLoaded), 128'h7);
      rd_check("rd_after_rst", 0, 16, 128'h5011);
      check_value("partial_err0", 128'(err), 128'd0);
      startCompute = 1'b1;
      tick();
      startCompute = 1'b0;
      check_value("refuse_go", 128'(computeGo), 128'd0);
      check_value("refuse_err", 128'(err), 128'd1);
      check_value("refuse_state", 128'(state), 128'd0);
      tick();
      check_value("refuse_go2", 128'(computeGo), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
